// File: rtl/alu_regfile_datapath.sv
// 8-bit execution datapath: 8x8 register file, operand-B conditioning,
// 3-bit ALU with zero flag. ALU result feeds the register write port.
module mux2x1_var #(
  parameter int WIDTH = 8
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out
);

  // sel=0 picks in0, sel=1 picks in1
  always_comb begin
    out = sel ? in1 : in0;
  end

endmodule

module alu_regfile_datapath #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [2:0]        alu_op,
  input  logic              use_imm,
  input  logic              op2_pos,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [ADDR_W-1:0] r_addr1,
  input  logic [ADDR_W-1:0] r_addr2,
  input  logic [WIDTH-1:0]  imm,
  output logic [WIDTH-1:0]  rd_data1,
  output logic [WIDTH-1:0]  rd_data2,
  output logic [WIDTH-1:0]  operand_b,
  output logic [WIDTH-1:0]  alu_result,
  output logic              zero
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [WIDTH-1:0] neg;
  logic [WIDTH-1:0] mux1;
  logic [2:0]       shamt;

  // Asynchronous read ports; no bypass of the pending write
  always_comb begin
    rd_data1 = regs_q[r_addr1];
    rd_data2 = regs_q[r_addr2];
  end

  // Two's complement of port-2 data for subtract
  always_comb begin
    neg = ~rd_data2 + ONE;
  end

  mux2x1_var #(.WIDTH(WIDTH)) u_mux_pos (
    .sel (op2_pos),
    .in0 (neg),
    .in1 (rd_data2),
    .out (mux1)
  );

  mux2x1_var #(.WIDTH(WIDTH)) u_mux_imm (
    .sel (use_imm),
    .in0 (mux1),
    .in1 (imm),
    .out (operand_b)
  );

  // ALU: IN1 = operand_b, IN2 = rd_data1; results wrap
  always_comb begin
    alu_result = '0;
    shamt      = operand_b[2:0];
    unique case (alu_op)
      OP_FWD: alu_result = operand_b;
      OP_ADD: alu_result = rd_data1 + operand_b;
      OP_AND: alu_result = rd_data1 & operand_b;
      OP_OR:  alu_result = rd_data1 | operand_b;
      OP_XOR: alu_result = rd_data1 ^ operand_b;
      OP_SLL: alu_result = rd_data1 << shamt;
      OP_SRL: alu_result = rd_data1 >> shamt;
      OP_RSV: alu_result = '0;
    endcase
  end

  // Zero flag for branch decisions
  always_comb begin
    zero = (alu_result == '0);
  end

  // Next register-file contents: one write port
  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[w_addr] = alu_result;
    end
  end

  // Register file state; reset clears every entry at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: tb/tb_alu_regfile_datapath.sv
// Directed bench for alu_regfile_datapath with an expected-value queue.
// Inputs change on the falling edge; outputs sampled away from rising edge.
module tb_alu_regfile_datapath;

  logic       clk = 1'b0;
  logic       rst;
  logic       we;
  logic [2:0] alu_op;
  logic       use_imm;
  logic       op2_pos;
  logic [2:0] w_addr;
  logic [2:0] r_addr1;
  logic [2:0] r_addr2;
  logic [7:0] imm;
  logic [7:0] rd_data1;
  logic [7:0] rd_data2;
  logic [7:0] operand_b;
  logic [7:0] alu_result;
  logic       zero;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  alu_regfile_datapath dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .alu_op     (alu_op),
    .use_imm    (use_imm),
    .op2_pos    (op2_pos),
    .w_addr     (w_addr),
    .r_addr1    (r_addr1),
    .r_addr2    (r_addr2),
    .imm        (imm),
    .rd_data1   (rd_data1),
    .rd_data2   (rd_data2),
    .operand_b  (operand_b),
    .alu_result (alu_result),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [7:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [7:0] obs);
    logic [7:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s observed=%h expected=<queue empty>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  task automatic drive(input logic w, input logic [2:0] op,
                       input logic ui, input logic pos,
                       input logic [2:0] wa, input logic [2:0] ra1,
                       input logic [2:0] ra2, input logic [7:0] im);
    @(negedge clk);
    we = w; alu_op = op; use_imm = ui; op2_pos = pos;
    w_addr = wa; r_addr1 = ra1; r_addr2 = ra2; imm = im;
    #1;
  endtask

  task automatic load(input logic [2:0] wa, input logic [7:0] v);
    drive(1'b1, 3'b000, 1'b1, 1'b1, wa, 3'd0, 3'd0, v);
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; alu_op = '0; use_imm = 1'b0;
    op2_pos = 1'b1; w_addr = '0; r_addr1 = '0; r_addr2 = '0;
    imm = '0;
    #3;
    for (int i = 0; i < 8; i++) begin
      r_addr1 = 3'(i); r_addr2 = 3'(7 - i);
      #1;
      push(8'h00); check($sformatf("rst_rd1_%0d", i), rd_data1);
      push(8'h00); check($sformatf("rst_rd2_%0d", i), rd_data2);
    end
    @(negedge clk);
    rst = 1'b1;

    // load immediates
    drive(1'b1, 3'b000, 1'b1, 1'b1, 3'd1, 3'd1, 3'd1, 8'h05);
    push(8'h00); check("li_old", rd_data1);
    push(8'h05); check("li_res", alu_result);
    @(posedge clk); #1;
    push(8'h05); check("li_new", rd_data1);
    load(3'd2, 8'h03);
    drive(1'b0, 3'b000, 1'b0, 1'b1, 3'd0, 3'd1, 3'd2, 8'h00);
    push(8'h03); check("r2", rd_data2);

    // add / subtract
    drive(1'b0, 3'b001, 1'b0, 1'b1, 3'd0, 3'd1, 3'd2, 8'h00);
    push(8'h08); check("add", alu_result);
    push(8'h00); check("add_z", {7'b0, zero});
    drive(1'b0, 3'b001, 1'b0, 1'b0, 3'd0, 3'd1, 3'd2, 8'h00);
    push(8'hFD); check("neg3", operand_b);
    push(8'h02); check("sub", alu_result);
    drive(1'b0, 3'b001, 1'b0, 1'b0, 3'd0, 3'd1, 3'd1, 8'h00);
    push(8'h00); check("r1-r1", alu_result);
    push(8'h01); check("r1-r1_z", {7'b0, zero});

    // wrap-around and negate boundaries
    load(3'd3, 8'hFF);
    drive(1'b0, 3'b001, 1'b1, 1'b1, 3'd0, 3'd3, 3'd0, 8'h01);
    push(8'h00); check("wrap", alu_result);
    push(8'h01); check("wrap_z", {7'b0, zero});
    load(3'd4, 8'h80);
    drive(1'b0, 3'b000, 1'b0, 1'b0, 3'd0, 3'd0, 3'd4, 8'h00);
    push(8'h80); check("neg80", operand_b);
    drive(1'b0, 3'b000, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00);
    push(8'h00); check("neg00", operand_b);

    // logic ops
    load(3'd5, 8'hF0);
    load(3'd6, 8'h3C);
    drive(1'b0, 3'b010, 1'b0, 1'b1, 3'd0, 3'd5, 3'd6, 8'h00);
    push(8'h30); check("and", alu_result);
    drive(1'b0, 3'b011, 1'b0, 1'b1, 3'd0, 3'd5, 3'd6, 8'h00);
    push(8'hFC); check("or", alu_result);
    drive(1'b0, 3'b100, 1'b0, 1'b1, 3'd0, 3'd5, 3'd6, 8'h00);
    push(8'hCC); check("xor", alu_result);

    // shifts
    load(3'd7, 8'h81);
    drive(1'b0, 3'b101, 1'b1, 1'b1, 3'd0, 3'd7, 3'd0, 8'h01);
    push(8'h02); check("sll1", alu_result);
    drive(1'b0, 3'b110, 1'b1, 1'b1, 3'd0, 3'd7, 3'd0, 8'h07);
    push(8'h01); check("srl7", alu_result);
    drive(1'b0, 3'b110, 1'b1, 1'b1, 3'd0, 3'd7, 3'd0, 8'h09);
    push(8'h40); check("srl_mask", alu_result);
    drive(1'b0, 3'b111, 1'b1, 1'b1, 3'd0, 3'd7, 3'd0, 8'hFF);
    push(8'h00); check("op7", alu_result);
    push(8'h01); check("op7_z", {7'b0, zero});

    // we=0 holds the target register
    drive(1'b0, 3'b000, 1'b1, 1'b1, 3'd1, 3'd1, 3'd0, 8'hAA);
    repeat (3) @(posedge clk);
    #1;
    push(8'h05); check("we0_hold", rd_data1);

    // same-cycle read of write address, then dependent read
    drive(1'b1, 3'b000, 1'b1, 1'b1, 3'd1, 3'd1, 3'd0, 8'h77);
    push(8'h05); check("rw_old", rd_data1);
    @(posedge clk); #1;
    push(8'h77); check("rw_new", rd_data1);
    drive(1'b1, 3'b001, 1'b1, 1'b1, 3'd2, 3'd1, 3'd2, 8'h01);
    push(8'h78); check("dep_add", alu_result);
    @(posedge clk); #1;
    we = 1'b0;
    push(8'h78); check("dep_wr", rd_data2);

    // register 0 is writable
    load(3'd0, 8'h11);
    drive(1'b0, 3'b000, 1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 8'h00);
    push(8'h11); check("r0_wr", rd_data1);

    // mid-run reset clears immediately and blocks writes
    drive(1'b1, 3'b000, 1'b1, 1'b1, 3'd1, 3'd1, 3'd7, 8'h55);
    #1;
    rst = 1'b0;
    #1;
    push(8'h00); check("mid_rst_r1", rd_data1);
    push(8'h00); check("mid_rst_r7", rd_data2);
    @(posedge clk); #1;
    push(8'h00); check("rst_blk_wr", rd_data1);
    for (int i = 0; i < 8; i++) begin
      r_addr1 = 3'(i);
      #1;
      push(8'h00); check($sformatf("mid_rst_all_%0d", i), rd_data1);
    end
    @(negedge clk);
    we = 1'b0;
    rst = 1'b1;

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover observed=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_regfile_datapath.md
Name: alu_regfile_datapath

Overview:
8-bit execution datapath for the single-cycle CPU. It contains:
- an 8x8 register file with two combinational read ports and one clocked write port;
- operand-B conditioning: a negate path (two's complement), a positive/negated select and an immediate select;
- a 3-bit-op ALU with a zero flag.

The ALU result is the register-file write data. Operand B and the zero flag are exported so the PC logic can compute jump and branch targets.

Parameters:
WIDTH, 8, data width of registers, ALU and operand muxes
ADDR_W, 3, register address width (2**ADDR_W registers)

Ports:
clk  input  1  clock; register writes occur on rising edge
rst  input  1  asynchronous, active-low reset; clears all registers
we  input  1  register write enable (opcode bit 7)
alu_op  input  3  ALU operation select (opcode bits 6:4)
use_imm  input  1  1 = operand B is imm (opcode bit 3)
op2_pos  input  1  1 = operand B is rd_data2; 0 = two's complement of rd_data2 (opcode bit 2)
w_addr  input  ADDR_W  write register address
r_addr1  input  ADDR_W  read port 1 address (operand A source)
r_addr2  input  ADDR_W  read port 2 address (operand B source)
imm  input  WIDTH  immediate value
rd_data1  output  WIDTH  register[r_addr1], combinational
rd_data2  output  WIDTH  register[r_addr2], combinational
operand_b  output  WIDTH  selected operand B (jump/immediate target)
alu_result  output  WIDTH  ALU output, also the register write data
zero  output  1  1 when alu_result == 0

Behaviour:
- Reset:
  - rst low immediately, without waiting for clk, forces all 8 registers to 0.
  - While rst is low, writes are blocked.
  - After reset, rd_data1 = rd_data2 = 0.
  - Outputs remain combinational functions of the register contents and inputs.
- Write:
  - On the rising edge of clk with rst high and we=1, register[w_addr] <= alu_result.
  - With we=0, nothing is written.
  - All 8 registers are writable; register 0 is not hardwired.
- Read:
  - Both ports are asynchronous/combinational.
  - Reading the address being written returns the old value until the edge, then the new value; there is no write-through bypass.
  - Both ports may read the same address.
- Operand B:
  - neg = (~rd_data2 + 1) mod 2**WIDTH; negating 0x00 gives 0x00, negating 0x80 gives 0x80.
  - mux1 = op2_pos ? rd_data2 : neg.
  - operand_b = use_imm ? imm : mux1.
  - Each mux2x1_var is a WIDTH-parameterised 2:1 mux: sel=0 selects in0, sel=1 selects in1.
- ALU: operands IN1 = operand_b, IN2 = rd_data1. All operations are purely combinational and modulo 2**WIDTH; carry/overflow is discarded.
  - 000 FORWARD: IN1
  - 001 ADD: IN2 + IN1 (subtract is ADD with op2_pos=0)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLL: IN2 << IN1[2:0]
  - 110 SRL: IN2 >> IN1[2:0], logical shift
  - 111 reserved, output 0x00
- Zero flag:
  - zero = (alu_result == 0), valid combinationally in the same cycle.
  - Used by the CPU for BEQ/BNE decisions.
- Timing:
  - Single-cycle: an instruction's result is written at the next rising edge.
  - A dependent read in the following cycle sees the new value.

Test Plan:
- Reset, then read addresses 0..7 on both ports -> all read 0x00. Assert rst low mid-run after writes -> registers clear immediately, before the next clk edge.
- Load immediate: we=1, alu_op=000, use_imm=1, imm=0x05, w_addr=1, one clock -> rd_data1 at r_addr1=1 reads 0x05. Repeat with imm=0x03 to r2 -> r2 reads 0x03.
- Add and subtract with r1=5, r2=3, use_imm=0:
  - alu_op=001, op2_pos=1 -> alu_result 0x08, zero=0.
  - op2_pos=0 -> 0x02.
  - r1-r1 (r_addr1=r_addr2=1, op2_pos=0) -> 0x00, zero=1.
- Wrap-around: r1=0xFF plus imm 0x01 with ADD -> 0x00, zero=1. Negating 0x80 -> operand_b 0x80.
- Logic and shifts on 0xF0 and 0x3C:
  - AND -> 0x30; OR -> 0xFC; XOR -> 0xCC.
  - SLL of 0x81 by 1 -> 0x02.
  - SRL of 0x81 by 7 -> 0x01.
  - op 111 -> 0x00, zero=1.
- we=0 with a nonzero alu_result over several edges -> target register unchanged. Same-cycle read of the write address shows the old value before the edge and the new value after it.
